// File: rtl/ysyx_23060077_icache_pkg.sv
// Shared geometry, address-field widths and FSM encoding for the instruction cache.
package ysyx_23060077_icache_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int LEN_WIDTH  = 8;
  localparam int LINE_WORDS = 4;
  localparam int NUM_SETS   = 16;

  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int OFF_W   = WORD_W + 2;
  localparam int TAG_W   = ADDR_WIDTH - OFF_W - INDEX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

endpackage

// File: rtl/ysyx_23060077_icache_array.sv
// Tag/valid/data storage: one write port (word write plus tag/valid set),
// combinational read, and a global valid-clear that overrides a same-cycle set.
module ysyx_23060077_icache_array
  import ysyx_23060077_icache_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [INDEX_W-1:0]    wr_index_i,
  input  logic [WORD_W-1:0]     wr_word_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  set_valid_i,
  input  logic [TAG_W-1:0]      set_tag_i,
  input  logic [INDEX_W-1:0]    rd_index_i,
  input  logic [WORD_W-1:0]     rd_word_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic                  rd_valid_o
);

  logic [DATA_WIDTH-1:0] data_q [NUM_SETS][LINE_WORDS];
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0]   valid_q, valid_d;

  // NOTE: start from the held value so every path assigns valid_d and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    if (set_valid_i) valid_d[wr_index_i] = 1'b1;
    if (clear_i)     valid_d = '0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: data and tags are not reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en_i)     data_q[wr_index_i][wr_word_i] <= wr_data_i;
    if (set_valid_i) tag_q[wr_index_i]             <= set_tag_i;
  end

  assign rd_data_o  = data_q[rd_index_i][rd_word_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/ysyx_23060077_icache.sv
// Direct-mapped read-only instruction cache: lookup, whole-line burst refill,
// and fence.i invalidation on the rising edge of ifu_fence_i.
module ysyx_23060077_icache
  import ysyx_23060077_icache_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_valid_i,
  input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_ready_o,
  output logic [DATA_WIDTH-1:0] ifu_data_o,
  input  logic                  ifu_fence_i,
  output logic                  Icache_r_valid_o,
  output logic [ADDR_WIDTH-1:0] Icache_r_addr_o,
  input  logic                  Icache_r_ready_i,
  input  logic [DATA_WIDTH-1:0] Icache_r_data_i,
  output logic [LEN_WIDTH-1:0]  Icache_r_len_o,
  input  logic                  Icache_r_last_i
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:2] addr_q, addr_d;
  logic [WORD_W-1:0]     beat_q, beat_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  r_valid_q, r_valid_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic                  fence_prev_q;

  logic [WORD_W-1:0]     addr_word;
  logic [INDEX_W-1:0]    addr_index;
  logic [TAG_W-1:0]      addr_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_valid;
  logic                  hit;
  logic                  fence_rise;
  logic                  wr_en;
  logic                  set_valid;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^ifu_addr_i[1:0];

  assign addr_word  = addr_q[OFF_W-1:2];
  assign addr_index = addr_q[OFF_W+INDEX_W-1:OFF_W];
  assign addr_tag   = addr_q[ADDR_WIDTH-1:OFF_W+INDEX_W];
  assign hit        = rd_valid && (rd_tag == addr_tag);
  assign fence_rise = ifu_fence_i && !fence_prev_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
    ready_d   = 1'b0;
    data_d    = data_q;
    r_valid_d = r_valid_q;
    r_addr_d  = r_addr_q;
    wr_en     = 1'b0;
    set_valid = 1'b0;
    case (state_q)
      // A request still held high during its own ready cycle must not be re-accepted.
      S_IDLE: begin
        if (ifu_valid_i && !ready_q) begin
          addr_d  = ifu_addr_i[ADDR_WIDTH-1:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          ready_d = 1'b1;
          data_d  = rd_data;
          state_d = S_IDLE;
        end else begin
          r_valid_d = 1'b1;
          r_addr_d  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          beat_d    = '0;
          state_d   = S_REFILL;
        end
      end
      S_REFILL: begin
        if (Icache_r_ready_i) begin
          wr_en  = 1'b1;
          beat_d = beat_q + WORD_W'(1);
          if (beat_q == addr_word) resp_d = Icache_r_data_i;
          if (Icache_r_last_i) begin
            set_valid = 1'b1;
            r_valid_d = 1'b0;
            ready_d   = 1'b1;
            data_d    = (beat_q == addr_word) ? Icache_r_data_i : resp_q;
            state_d   = S_RESP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      resp_q       <= '0;
      ready_q      <= 1'b0;
      data_q       <= '0;
      r_valid_q    <= 1'b0;
      r_addr_q     <= '0;
      fence_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      resp_q       <= resp_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      r_valid_q    <= r_valid_d;
      r_addr_q     <= r_addr_d;
      fence_prev_q <= ifu_fence_i;
    end
  end

  ysyx_23060077_icache_array u_array (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (fence_rise),
    .wr_en_i     (wr_en),
    .wr_index_i  (addr_index),
    .wr_word_i   (beat_q),
    .wr_data_i   (Icache_r_data_i),
    .set_valid_i (set_valid),
    .set_tag_i   (addr_tag),
    .rd_index_i  (addr_index),
    .rd_word_i   (addr_word),
    .rd_data_o   (rd_data),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid)
  );

  assign ifu_ready_o      = ready_q;
  assign ifu_data_o       = data_q;
  assign Icache_r_valid_o = r_valid_q;
  assign Icache_r_addr_o  = r_addr_q;
  assign Icache_r_len_o   = LEN_WIDTH'(LINE_WORDS - 1);

endmodule

// File: tb/tb_ysyx_23060077_icache.sv
// Directed bench for the instruction cache: misses, hits, conflicts, fence.i,
// reset mid-burst and gapped refill beats, all with hand-computed expectations.
module tb_ysyx_23060077_icache;

  logic        clock;
  logic        reset;
  logic        ifu_valid_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_ready_o;
  logic [31:0] ifu_data_o;
  logic        ifu_fence_i;
  logic        Icache_r_valid_o;
  logic [31:0] Icache_r_addr_o;
  logic        Icache_r_ready_i;
  logic [31:0] Icache_r_data_i;
  logic [7:0]  Icache_r_len_o;
  logic        Icache_r_last_i;

  int n_vec = 0;
  int n_err = 0;

  ysyx_23060077_icache dut (
    .clock            (clock),
    .reset            (reset),
    .ifu_valid_i      (ifu_valid_i),
    .ifu_addr_i       (ifu_addr_i),
    .ifu_ready_o      (ifu_ready_o),
    .ifu_data_o       (ifu_data_o),
    .ifu_fence_i      (ifu_fence_i),
    .Icache_r_valid_o (Icache_r_valid_o),
    .Icache_r_addr_o  (Icache_r_addr_o),
    .Icache_r_ready_i (Icache_r_ready_i),
    .Icache_r_data_i  (Icache_r_data_i),
    .Icache_r_len_o   (Icache_r_len_o),
    .Icache_r_last_i  (Icache_r_last_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hit: ready exactly in the second cycle after valid is first sampled, no burst.
  task automatic fetch_hit(input string name, input logic [31:0] addr, input logic [31:0] exp);
    ifu_valid_i = 1'b1;
    ifu_addr_i  = addr;
    @(negedge clock);
    check({name, " early ready"}, {31'd0, ifu_ready_o}, 32'd0);
    @(negedge clock);
    check({name, " ready"}, {31'd0, ifu_ready_o}, 32'd1);
    check({name, " data"}, ifu_data_o, exp);
    check({name, " no burst"}, {31'd0, Icache_r_valid_o}, 32'd0);
    ifu_valid_i = 1'b0;
    @(negedge clock);
    check({name, " ready drop"}, {31'd0, ifu_ready_o}, 32'd0);
  endtask

  // Miss: burst request, four beats (optionally gapped), single ready pulse after last beat.
  task automatic fetch_miss(input string name, input logic [31:0] addr,
                            input logic [31:0] line_addr, input logic [3:0][31:0] beats,
                            input int gap, input bit fence_last, input logic [31:0] exp);
    int pulses;
    pulses      = 0;
    ifu_valid_i = 1'b1;
    ifu_addr_i  = addr;
    @(negedge clock);
    if (ifu_ready_o) pulses++;
    @(negedge clock);
    check({name, " r_valid"}, {31'd0, Icache_r_valid_o}, 32'd1);
    check({name, " r_addr"}, Icache_r_addr_o, line_addr);
    check({name, " r_len"}, {24'd0, Icache_r_len_o}, 32'd3);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        Icache_r_ready_i = 1'b0;
        Icache_r_data_i  = 32'hDEAD_BEEF;
        Icache_r_last_i  = 1'b1;
        @(negedge clock);
        if (ifu_ready_o) pulses++;
      end
      Icache_r_ready_i = 1'b1;
      Icache_r_data_i  = beats[k];
      Icache_r_last_i  = (k == 3);
      if (k == 3 && fence_last) ifu_fence_i = 1'b1;
      @(negedge clock);
      if (k < 3 && ifu_ready_o) pulses++;
    end
    Icache_r_ready_i = 1'b0;
    Icache_r_last_i  = 1'b0;
    Icache_r_data_i  = 32'h0;
    check({name, " early pulses"}, pulses, 32'd0);
    check({name, " ready"}, {31'd0, ifu_ready_o}, 32'd1);
    check({name, " data"}, ifu_data_o, exp);
    check({name, " r_valid drop"}, {31'd0, Icache_r_valid_o}, 32'd0);
    ifu_valid_i = 1'b0;
    if (fence_last) ifu_fence_i = 1'b0;
    @(negedge clock);
    check({name, " ready drop"}, {31'd0, ifu_ready_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset            = 1'b0;
    ifu_valid_i      = 1'b0;
    ifu_addr_i       = 32'h0;
    ifu_fence_i      = 1'b0;
    Icache_r_ready_i = 1'b0;
    Icache_r_data_i  = 32'h0;
    Icache_r_last_i  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst ready", {31'd0, ifu_ready_o}, 32'd0);
    check("rst data", ifu_data_o, 32'd0);
    check("rst r_valid", {31'd0, Icache_r_valid_o}, 32'd0);
    check("rst r_addr", Icache_r_addr_o, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Cold miss, then hits on the same line.
    fetch_miss("cold", 32'h3000_0004, 32'h3000_0000,
               {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0, 32'h22);
    fetch_hit("hit8", 32'h3000_0008, 32'h33);
    fetch_hit("hitC", 32'h3000_000C, 32'h44);
    fetch_hit("hit0", 32'h3000_0000, 32'h11);

    // Conflict on index 0, then the evicted line misses again with gapped beats.
    fetch_miss("conflict", 32'h3000_0100, 32'h3000_0100,
               {32'h88, 32'h77, 32'h66, 32'h55}, 0, 1'b0, 32'h55);
    fetch_hit("hit100C", 32'h3000_010C, 32'h88);
    fetch_miss("evicted", 32'h3000_0000, 32'h3000_0000,
               {32'h44, 32'h33, 32'h22, 32'h11}, 2, 1'b0, 32'h11);

    // A different set coexists with index 0.
    fetch_miss("set1", 32'h3000_0018, 32'h3000_0010,
               {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 1, 1'b0, 32'hA3);
    fetch_hit("set0 kept", 32'h3000_0004, 32'h22);

    // Beats arriving while idle must be ignored.
    Icache_r_ready_i = 1'b1;
    Icache_r_last_i  = 1'b1;
    Icache_r_data_i  = 32'hBAD0_BAD0;
    repeat (2) @(negedge clock);
    Icache_r_ready_i = 1'b0;
    Icache_r_last_i  = 1'b0;
    check("stray r_valid", {31'd0, Icache_r_valid_o}, 32'd0);
    fetch_hit("stray ignored", 32'h3000_0008, 32'h33);

    // fence.i rising edge invalidates; holding it high does not clear again.
    ifu_fence_i = 1'b1;
    @(negedge clock);
    fetch_miss("fence miss", 32'h3000_0008, 32'h3000_0000,
               {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 0, 1'b0, 32'hB3);
    fetch_hit("fence held", 32'h3000_0008, 32'hB3);
    fetch_miss("fence set1", 32'h3000_0014, 32'h3000_0010,
               {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 0, 1'b0, 32'hA2);
    ifu_fence_i = 1'b0;
    @(negedge clock);

    // Fence edge coinciding with the last beat: response returned, line left invalid.
    fetch_miss("fence last", 32'h3000_0044, 32'h3000_0040,
               {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 0, 1'b1, 32'hC2);
    fetch_miss("fence last re", 32'h3000_0048, 32'h3000_0040,
               {32'hD4, 32'hD3, 32'hD2, 32'hD1}, 0, 1'b0, 32'hD3);

    // Reset mid-burst abandons the refill and clears every line.
    ifu_valid_i = 1'b1;
    ifu_addr_i  = 32'h3000_0020;
    repeat (2) @(negedge clock);
    check("midrst r_valid", {31'd0, Icache_r_valid_o}, 32'd1);
    Icache_r_ready_i = 1'b1;
    Icache_r_data_i  = 32'hE1;
    @(negedge clock);
    reset       = 1'b0;
    ifu_valid_i = 1'b0;
    Icache_r_data_i = 32'hE2;
    @(negedge clock);
    check("midrst r_valid low", {31'd0, Icache_r_valid_o}, 32'd0);
    check("midrst ready", {31'd0, ifu_ready_o}, 32'd0);
    check("midrst r_addr", Icache_r_addr_o, 32'd0);
    Icache_r_ready_i = 1'b0;
    Icache_r_data_i  = 32'h0;
    reset = 1'b1;
    @(negedge clock);
    check("postrst r_valid", {31'd0, Icache_r_valid_o}, 32'd0);
    fetch_miss("postrst miss", 32'h3000_0008, 32'h3000_0000,
               {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 0, 1'b0, 32'hF3);
    fetch_miss("postrst 20", 32'h3000_0020, 32'h3000_0020,
               {32'hE4, 32'hE3, 32'hE2, 32'hE1}, 3, 1'b0, 32'hE1);
    fetch_hit("postrst hit", 32'h3000_002C, 32'hE4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
